mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter ALIGN_CHECK, default 1, meaning flag misaligned halfword/word accesses as errors; when 0, ignore the low address bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1: request a new access; sampled only in IDLE.
REQ-005 Port op, input, 3: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-006 Port addr, input, 32: byte address, sampled with start.
REQ-007 Port wdata, input, 32: store data, sampled with start; SH uses [15:0], SB uses [7:0].
REQ-008 Port rdata, output, 32: extended load result.
REQ-009 Port done, output, 1: one-cycle completion pulse.
REQ-010 Port busy, output, 1: high in any non-IDLE state.
REQ-011 Port err, output, 1: misalignment flag, valid with done.
REQ-012 Port mem_req, output, 1: word-memory request.
REQ-013 Port mem_we, output, 1: write strobe qualifying mem_req.
REQ-014 Port mem_addr, output, 32: word address with bits [1:0] = 00.
REQ-015 Port mem_wdata, output, 32: full-word write data.
REQ-016 Port mem_rdata, input, 32: read data, valid when mem_ready is high.
REQ-017 Port mem_ready, input, 1: memory accepts or completes the request this cycle.

Function
REQ-018 The FSM SHALL use states IDLE, RD, WR, DONE.
REQ-019 Transitions SHALL be: IDLE+start -> RD for loads, SB and SH; IDLE+start -> WR for SW; IDLE+start+misaligned -> DONE with err=1 and no memory access.
REQ-020 RD SHALL wait until mem_ready; it SHALL then go to DONE for loads and to WR for SB/SH.
REQ-021 WR SHALL wait until mem_ready and then go to DONE; DONE SHALL go to IDLE unconditionally.
REQ-022 Misalignment SHALL be defined as: LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] = 1; byte operations are never misaligned.
REQ-023 Byte lanes SHALL be little-endian: byte k occupies bits [8k+7:8k] with k = addr[1:0]; halfword h occupies bits [16h+15:16h] with h = addr[1].
REQ-024 LB/LH SHALL sign-extend the selected lane to 32 bits, LBU/LHU SHALL zero-extend it, and LW SHALL pass the word unchanged.
REQ-025 SB/SH SHALL be read-modify-write: replace only the target lane of the word read in RD, and preserve the other bytes exactly.
REQ-026 mem_req SHALL be high in RD and WR only, and mem_we SHALL be high in WR only; mem_addr and mem_wdata SHALL be stable while mem_req is high.
REQ-027 rdata SHALL update only on load completion and SHALL hold until the next load completes; stores and errors SHALL leave it unchanged.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 Latency with mem_ready tied high SHALL be: done at start+2 for loads and SW, and start+3 for SB/SH; each extra wait cycle of mem_ready SHALL add one cycle.
REQ-030 err SHALL be cleared at the next accepted start.

Reset
REQ-031 While rst=1 the unit SHALL enter IDLE and drive rdata, done, busy, err, mem_req, mem_we, mem_addr and mem_wdata to 0.
REQ-032 Reset mid-access SHALL abandon the operation: mem_req low the next cycle, no done pulse, and no partial write issued after reset.

Structure
REQ-033 The op encodings and state encodings SHALL reside in a shared package/header, mau_pkg.
REQ-034 The combinational lane-select and extension logic SHALL be a sub-module, load_extend (inputs word, addr[1:0], op; output 32-bit result).

Verification
REQ-035 Scenario: mem word 0x80FF7F01 at 0x100; LB at 0x100, 0x101, 0x103 -> rdata 0x00000001, 0x0000007F, 0xFFFFFF80; LBU at 0x103 -> 0x00000080.
REQ-036 Scenario: same word; LH at 0x102 -> 0xFFFF80FF; LHU at 0x102 -> 0x000080FF; LW at 0x100 -> 0x80FF7F01 with done at cycle start+2 when mem_ready is tied high.
REQ-037 Scenario: mem 0x11223344 at 0x200; SB 0xAA at 0x201 -> one read, one write of 0x1122AA44; SH 0xBEEF at 0x202 -> 0xBEEF3344; done at start+3.
REQ-038 Scenario: LW at 0x102 and SH at 0x201 -> done after 1 cycle, err=1, mem_req never asserted, memory unchanged; with ALIGN_CHECK=0 the same LW reads word 0x100.
REQ-039 Scenario: mem_ready held low 4 cycles during SW -> mem_req, mem_addr and mem_wdata stable throughout; a start pulse while busy is ignored.
REQ-040 Scenario: rst asserted in WR of an SB -> mem_req=0 the next cycle, no done, all outputs 0, and the following LW completes normally.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings and lane helpers for the memory access unit.
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LW, OP_SW:         mis = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = a[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Replace only the addressed lane; untouched bytes come from the word just read.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  a,
                                                input op_e         op);
        logic [31:0] r;
        r = word;
        if (op == OP_SB)
            r[{a, 3'b000} +: 8] = data[7:0];
        else if (op == OP_SH)
            r[{a[1], 4'b0000} +: 16] = data[15:0];
        return r;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Little-endian lane select with sign/zero extension for load results.
module load_extend
    import mau_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  op_e         op,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = word[{addr[1], 4'b0000} +: 16];
        result = word;
        case (op)
            OP_LB:   result = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  result = {24'h000000, lane_b};
            OP_LH:   result = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  result = {16'h0000, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store front end onto a word-wide memory port.
// state | meaning
// IDLE  | waiting for start
// RD    | word read outstanding (loads, and first half of SB/SH read-modify-write)
// WR    | word write outstanding
// DONE  | one-cycle completion, err valid
module mem_access_unit
    import mau_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] ext_result;

    load_extend u_load_extend (
        .word   (mem_rdata),
        .addr   (addr_q[1:0]),
        .op     (op_q),
        .result (ext_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    if (ALIGN_CHECK && is_misaligned(op_e'(op), addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (op_e'(op) == OP_SW) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ready) begin
                    if (is_load(op_q)) begin
                        rdata_d = ext_result;
                        state_d = DONE;
                    end else begin
                        wdata_d = merge_store(mem_rdata, wdata_q, addr_q[1:0], op_q);
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (mem_ready)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high so a reset mid-write cannot complete it.
    always_comb begin
        rdata     = rst ? 32'h0 : rdata_q;
        done      = !rst && (state_q == DONE);
        busy      = !rst && (state_q != IDLE);
        err       = !rst && err_q;
        mem_req   = !rst && ((state_q == RD) || (state_q == WR));
        mem_we    = !rst && (state_q == WR);
        mem_addr  = rst ? 32'h0 : {addr_q[31:2], 2'b00};
        mem_wdata = rst ? 32'h0 : wdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [2:0]  op;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        done, busy, err, mem_req, mem_we;

    logic        start2;
    logic [31:0] addr2, rdata2, m2_addr, m2_wdata, m2_rdata;
    logic        done2, busy2, err2, m2_req, m2_we;
    logic        ready2 = 1'b1;

    logic [31:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'h0;
    logic [31:0] bd_data = 32'h0;
    int          rd_cnt = 0, wr_cnt = 0, req_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;
    int lat, r0, w0, q0;

    always #5 clk = ~clk;

    mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .busy(busy), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_access_unit #(.ALIGN_CHECK(1'b0)) dut_noalign (
        .clk(clk), .rst(rst), .start(start2), .op(3'd0), .addr(addr2), .wdata(32'h0),
        .rdata(rdata2), .done(done2), .busy(busy2), .err(err2),
        .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
        .mem_rdata(m2_rdata), .mem_ready(ready2)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    assign m2_rdata  = mem[m2_addr[9:2]];

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_data;
        else if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_req && !mem_we && mem_ready) rd_cnt <= rd_cnt + 1;
        if (mem_req) req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_load(input logic [31:0] byte_addr, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = byte_addr[9:2]; bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issues one access and returns cycles from start to done (-1 on timeout).
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         output int latency);
        @(negedge clk);
        op = o; addr = a; wdata = w; start = 1'b1;
        r0 = rd_cnt; w0 = wr_cnt; q0 = req_cnt;
        @(negedge clk);
        start = 1'b0;
        latency = 1;
        while (!done && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        if (!done) latency = -1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0; mem_ready = 1'b1;
        start2 = 1'b0; addr2 = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_flags", {28'h0, done, busy, err, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        mem_load(32'h100, 32'h80FF7F01);
        do_op(3'd3, 32'h100, 32'h0, lat); check("lb_100", rdata, 32'h00000001);
        do_op(3'd3, 32'h101, 32'h0, lat); check("lb_101", rdata, 32'h0000007F);
        do_op(3'd3, 32'h103, 32'h0, lat); check("lb_103", rdata, 32'hFFFFFF80);
        do_op(3'd4, 32'h103, 32'h0, lat); check("lbu_103", rdata, 32'h00000080);
        do_op(3'd1, 32'h102, 32'h0, lat); check("lh_102", rdata, 32'hFFFF80FF);
        do_op(3'd2, 32'h102, 32'h0, lat); check("lhu_102", rdata, 32'h000080FF);
        do_op(3'd0, 32'h100, 32'h0, lat);
        check("lw_100", rdata, 32'h80FF7F01);
        check("lw_latency", 32'(lat), 32'd2);
        check("lw_err", {31'h0, err}, 32'h0);

        mem_load(32'h200, 32'h11223344);
        do_op(3'd7, 32'h201, 32'h000000AA, lat);
        check("sb_latency", 32'(lat), 32'd3);
        check("sb_reads", 32'(rd_cnt - r0), 32'd1);
        check("sb_writes", 32'(wr_cnt - w0), 32'd1);
        @(negedge clk);
        check("sb_mem", mem[8'h80], 32'h1122AA44);
        check("sb_rdata_hold", rdata, 32'h80FF7F01);

        mem_load(32'h200, 32'h11223344);
        do_op(3'd6, 32'h202, 32'h0000BEEF, lat);
        check("sh_latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("sh_mem", mem[8'h80], 32'hBEEF3344);

        do_op(3'd0, 32'h102, 32'h0, lat);
        check("mis_lw_latency", 32'(lat), 32'd1);
        check("mis_lw_err", {31'h0, err}, 32'h1);
        check("mis_lw_req", 32'(req_cnt - q0), 32'd0);
        check("mis_lw_rdata_hold", rdata, 32'h80FF7F01);
        do_op(3'd6, 32'h201, 32'h00001234, lat);
        check("mis_sh_latency", 32'(lat), 32'd1);
        check("mis_sh_err", {31'h0, err}, 32'h1);
        check("mis_sh_req", 32'(req_cnt - q0), 32'd0);
        @(negedge clk);
        check("mis_sh_mem", mem[8'h80], 32'hBEEF3344);
        check("err_hold_idle", {31'h0, err}, 32'h1);
        do_op(3'd4, 32'h101, 32'h0, lat);
        check("err_cleared", {31'h0, err}, 32'h0);
        check("lbu_101", rdata, 32'h0000007F);

        @(negedge clk);
        addr2 = 32'h102; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        check("noalign_done", {31'h0, done2}, 32'h1);
        check("noalign_err", {31'h0, err2}, 32'h0);
        check("noalign_lw", rdata2, 32'h80FF7F01);

        // SW with four wait cycles; a start pulse mid-access must be dropped
        @(negedge clk);
        op = 3'd5; addr = 32'h300; wdata = 32'hCAFEF00D; start = 1'b1; mem_ready = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin op = 3'd3; addr = 32'h100; end
            check("sw_wait_req", {31'h0, mem_req & mem_we}, 32'h1);
            check("sw_wait_addr", mem_addr, 32'h300);
            check("sw_wait_wdata", mem_wdata, 32'hCAFEF00D);
        end
        start = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("sw_wait_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        check("sw_idle_after", {30'h0, busy, mem_req}, 32'h0);
        check("sw_mem", mem[8'hC0], 32'hCAFEF00D);
        check("sw_reads", 32'(rd_cnt - r0), 32'd0);
        check("sw_writes", 32'(wr_cnt - w0), 32'd1);
        check("sw_rdata_hold", rdata, 32'h0000007F);

        mem_load(32'h200, 32'h11223344);
        @(negedge clk);
        op = 3'd7; addr = 32'h200; wdata = 32'h55; start = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b0;
        check("rst_sb_rd", {31'h0, mem_req & ~mem_we}, 32'h1);
        @(negedge clk);
        check("rst_sb_wr", {31'h0, mem_we}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req", {31'h0, mem_req}, 32'h0);
        check("rst_mid_flags", {29'h0, done, busy, err}, 32'h0);
        check("rst_mid_bus", mem_addr | mem_wdata | rdata, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", {30'h0, done, mem_req}, 32'h0);
        end
        check("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rst_mem_kept", mem[8'h80], 32'h11223344);
        do_op(3'd0, 32'h100, 32'h0, lat);
        check("post_rst_lw", rdata, 32'h80FF7F01);
        check("post_rst_latency", 32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
